// File: rtl/link_frame_decoder.sv
// Receive-side framer: hunts for SYNC_WORD, collects a 7-word game-state frame,
// verifies the XOR checksum and commits all fields atomically; a watchdog tracks link health.
module link_frame_decoder #(
    parameter logic [15:0] SYNC_WORD      = 16'hB10B,
    parameter int unsigned TIMEOUT_CYCLES = 6_500_000,
    parameter int unsigned TIMEOUT_W      = 23
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] rx_data,
    input  logic        rx_valid,
    output logic [11:0] pl2_posx,
    output logic [11:0] pl2_posy,
    output logic [11:0] ball_posx,
    output logic [11:0] ball_posy,
    output logic [3:0]  pl1_score,
    output logic [3:0]  pl2_score,
    output logic        flag_point,
    output logic        end_game,
    output logic        frame_valid,
    output logic        link_up,
    output logic [7:0]  err_cnt
);

    typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WD_EXPIRE = TIMEOUT_W'(TIMEOUT_CYCLES - 2);

    state_t               state, state_next;
    logic [2:0]           idx;
    logic [15:0]          acc;
    logic [11:0]          sh_px, sh_py, sh_bx, sh_by;
    logic [9:0]           sh_w5;
    logic [TIMEOUT_W-1:0] wd;

    logic start, store, reject, commit, nibble_bad, expire;

    // Expiry fires on the edge where the counter reaches its final value, so it is a single event
    assign expire = (wd == WD_EXPIRE);

    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT:    if (start) state_next = COLLECT;
            COLLECT: begin
                if (reject)                       state_next = HUNT;
                else if (store && idx == 3'd5)    state_next = CHECK;
            end
            CHECK:   if (rx_valid) state_next = HUNT;
            default: state_next = HUNT;
        endcase
        if (expire) state_next = HUNT;
    end

    always_comb begin
        start      = 1'b0;
        store      = 1'b0;
        reject     = 1'b0;
        commit     = 1'b0;
        nibble_bad = (rx_data[15:12] != 4'h0) && (idx != 3'd5);
        case (state)
            HUNT:    start = rx_valid && (rx_data == SYNC_WORD);
            COLLECT: begin
                store  = rx_valid && !nibble_bad;
                reject = rx_valid && nibble_bad;
            end
            CHECK:   begin
                commit = rx_valid && (rx_data == acc);
                reject = rx_valid && (rx_data != acc);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= 3'd1;
            acc         <= '0;
            sh_px       <= '0;
            sh_py       <= '0;
            sh_bx       <= '0;
            sh_by       <= '0;
            sh_w5       <= '0;
            pl2_posx    <= '0;
            pl2_posy    <= '0;
            ball_posx   <= '0;
            ball_posy   <= '0;
            pl1_score   <= '0;
            pl2_score   <= '0;
            flag_point  <= 1'b0;
            end_game    <= 1'b0;
            frame_valid <= 1'b0;
            link_up     <= 1'b0;
            err_cnt     <= '0;
            wd          <= '0;
        end else begin
            if (start) begin
                idx <= 3'd1;
                acc <= '0;
            end
            if (store) begin
                acc <= acc ^ rx_data;
                idx <= idx + 3'd1;
                case (idx)
                    3'd1:    sh_px <= rx_data[11:0];
                    3'd2:    sh_py <= rx_data[11:0];
                    3'd3:    sh_bx <= rx_data[11:0];
                    3'd4:    sh_by <= rx_data[11:0];
                    default: sh_w5 <= {rx_data[15:8], rx_data[1:0]};
                endcase
            end

            frame_valid <= commit;
            if (commit) begin
                pl2_posx   <= sh_px;
                pl2_posy   <= sh_py;
                ball_posx  <= sh_bx;
                ball_posy  <= sh_by;
                pl1_score  <= sh_w5[9:6];
                pl2_score  <= sh_w5[5:2];
                flag_point <= sh_w5[1];
                end_game   <= sh_w5[0];
            end

            if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

            if (commit)              wd <= '0;
            else if (wd != WD_LAST)  wd <= wd + 1'b1;

            if (commit)      link_up <= 1'b1;
            else if (expire) link_up <= 1'b0;
        end
    end

endmodule

// File: tb/tb_link_frame_decoder.sv
// Bench for link_frame_decoder: directed scenarios with random fields/gaps/garbage,
// checked every cycle against a queue-based frame model plus literal spot checks.
module tb_link_frame_decoder;

    localparam logic [15:0] SYNC = 16'hB10B;
    localparam int          T    = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [11:0] pl2_posx, pl2_posy, ball_posx, ball_posy;
    logic [3:0]  pl1_score, pl2_score;
    logic        flag_point, end_game, frame_valid, link_up;
    logic [7:0]  err_cnt;

    link_frame_decoder #(.SYNC_WORD(SYNC), .TIMEOUT_CYCLES(T), .TIMEOUT_W(23)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .pl2_posx(pl2_posx), .pl2_posy(pl2_posy), .ball_posx(ball_posx), .ball_posy(ball_posy),
        .pl1_score(pl1_score), .pl2_score(pl2_score), .flag_point(flag_point), .end_game(end_game),
        .frame_valid(frame_valid), .link_up(link_up), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit fv_seen = 0;

    // Reference model: words of the frame in progress kept in a queue
    bit          m_hunt = 1;
    logic [15:0] m_q[$];
    int          m_since = 0;
    bit          m_link = 0;
    int          m_err = 0;
    logic [11:0] m_px = '0, m_py = '0, m_bx = '0, m_by = '0;
    logic [3:0]  m_s1 = '0, m_s2 = '0;
    logic        m_fp = 0, m_eg = 0, m_fv = 0;

    task automatic check(string tag, logic [127:0] act, logic [127:0] exp);
        tests++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_step(bit r, bit v, logic [15:0] d);
        bit commit = 0;
        bit reject = 0;
        logic [15:0] x;
        if (r) begin
            m_hunt = 1; m_q.delete(); m_since = 0; m_link = 0; m_err = 0;
            m_px = '0; m_py = '0; m_bx = '0; m_by = '0; m_s1 = '0; m_s2 = '0;
            m_fp = 0; m_eg = 0; m_fv = 0;
            return;
        end
        m_fv = 0;
        if (v) begin
            if (m_hunt) begin
                if (d == SYNC) begin m_hunt = 0; m_q.delete(); end
            end else if (m_q.size() < 5) begin
                if (m_q.size() < 4 && d[15:12] != 4'h0) reject = 1;
                else m_q.push_back(d);
            end else begin
                x = '0;
                foreach (m_q[i]) x ^= m_q[i];
                if (d == x) commit = 1; else reject = 1;
            end
        end
        if (reject) begin
            m_hunt = 1;
            if (m_err < 255) m_err++;
        end
        if (commit) begin
            m_px = m_q[0][11:0]; m_py = m_q[1][11:0];
            m_bx = m_q[2][11:0]; m_by = m_q[3][11:0];
            m_s1 = m_q[4][15:12]; m_s2 = m_q[4][11:8];
            m_fp = m_q[4][1]; m_eg = m_q[4][0];
            m_fv = 1; m_link = 1; m_since = 0; m_hunt = 1;
        end else if (m_since < T - 1) begin
            m_since++;
            if (m_since == T - 1) begin m_link = 0; m_hunt = 1; end
        end
    endtask

    task automatic tick(bit r, bit v, logic [15:0] d);
        logic [7:0] e;
        rst = r; rx_valid = v; rx_data = d;
        @(posedge clk);
        model_step(r, v, d);
        #1;
        if (frame_valid === 1'b1) fv_seen = 1;
        e = 8'(m_err);
        check("outputs",
              {pl2_posx, pl2_posy, ball_posx, ball_posy, pl1_score, pl2_score,
               flag_point, end_game, frame_valid, link_up, err_cnt},
              {m_px, m_py, m_bx, m_by, m_s1, m_s2, m_fp, m_eg, m_fv, m_link, e});
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(0, 0, 16'($urandom()));
    endtask

    task automatic word(logic [15:0] d, int gap_max);
        idle(gap_max == 0 ? 0 : int'($urandom_range(gap_max, 0)));
        tick(0, 1, d);
    endtask

    task automatic frame(logic [15:0] w1, logic [15:0] w2, logic [15:0] w3,
                         logic [15:0] w4, logic [15:0] w5, logic [15:0] flip, int gap_max);
        word(SYNC, gap_max);
        word(w1, gap_max); word(w2, gap_max); word(w3, gap_max);
        word(w4, gap_max); word(w5, gap_max);
        word(w1 ^ w2 ^ w3 ^ w4 ^ w5 ^ flip, gap_max);
    endtask

    initial begin
        logic [15:0] g;
        logic [15:0] r1, r2, r3, r4, r5;
        int          e0;
        int          n;

        tick(1, 0, '0);
        tick(1, 0, '0);
        check("reset_state", {pl2_posx, ball_posy, pl1_score, frame_valid, link_up, err_cnt}, '0);

        // 1: good frame, back-to-back words
        frame(16'h012C, 16'h0258, 16'h0200, 16'h0100, 16'h3502, 16'h0, 0);
        check("t1_pl2_posx", pl2_posx, 300);
        check("t1_pl2_posy", pl2_posy, 600);
        check("t1_ball_posx", ball_posx, 512);
        check("t1_ball_posy", ball_posy, 256);
        check("t1_scores", {pl1_score, pl2_score}, 8'h35);
        check("t1_flags", {flag_point, end_game}, 2'b10);
        check("t1_fv_link", {frame_valid, link_up}, 2'b11);
        idle(1);
        check("t1_fv_one_cycle", frame_valid, 0);

        // 2: bad checksum, then the same frame good
        fv_seen = 0;
        frame(16'h012C, 16'h0258, 16'h0200, 16'h0100, 16'h3502, 16'h0001, 0);
        idle(2);
        check("t2_no_commit", fv_seen, 0);
        check("t2_err", err_cnt, 1);
        check("t2_hold", {pl2_posx, pl1_score}, {12'd300, 4'd3});
        frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h9A03, 16'h0, 2);
        check("t2_recommit", {frame_valid, pl2_posx, ball_posy}, {1'b1, 12'h011, 12'h044});

        // 3: illegal nibble in w2, rest of frame ignored
        e0 = int'(err_cnt);
        fv_seen = 0;
        frame(16'h0123, 16'hF258, 16'h0200, 16'h0100, 16'h3502, 16'h0, 0);
        check("t3_err", err_cnt, 8'(e0 + 1));
        check("t3_no_commit", fv_seen, 0);
        r1 = 16'($urandom_range(4095, 0)); r2 = 16'($urandom_range(4095, 0));
        frame(r1, r2, 16'h0777, 16'h0888, 16'h4401, 16'h0, 3);
        check("t3_good_after", {frame_valid, pl2_posx, pl2_posy}, {1'b1, r1[11:0], r2[11:0]});

        // 4: random garbage before sync
        e0 = int'(err_cnt);
        for (int i = 0; i < 10; i++) begin
            do g = 16'($urandom()); while (g == SYNC);
            tick(0, 1, g);
        end
        r1 = 16'($urandom_range(4095, 0)); r2 = 16'($urandom_range(4095, 0));
        r3 = 16'($urandom_range(4095, 0)); r4 = 16'($urandom_range(4095, 0));
        r5 = {8'($urandom()), 6'b0, 2'($urandom())};
        frame(r1, r2, r3, r4, r5, 16'h0, 2);
        check("t4_commit", frame_valid, 1);
        check("t4_fields", {ball_posx, ball_posy, pl2_score, end_game},
              {r3[11:0], r4[11:0], r5[11:8], r5[0]});
        check("t4_err_same", err_cnt, 8'(e0));

        // 5: timeout after silence
        frame(16'h0ABC, 16'h0DEF, 16'h0123, 16'h0456, 16'h7F02, 16'h0, 0);
        n = 0;
        for (int i = 1; i <= 2 * T; i++) begin
            idle(1);
            n = i;
            if (link_up !== 1'b1) break;
        end
        check("t5_drop_cycles", n, T - 1);
        check("t5_link_down", link_up, 0);
        check("t5_hold", {pl2_posx, ball_posy, pl1_score}, {12'hABC, 12'h456, 4'h7});
        frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h1100, 16'h0, 1);
        check("t5_link_back", {link_up, frame_valid}, 2'b11);

        // 6: saturation, then reset mid-frame
        for (int i = 0; i < 300; i++)
            frame(16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h2200, 16'h8000, 0);
        check("t6_saturate", err_cnt, 8'hFF);
        word(SYNC, 0); word(16'h0015, 0); word(16'h0016, 0);
        tick(1, 0, '0);
        check("t6_reset_outputs", {pl2_posx, pl2_posy, ball_posx, ball_posy, pl1_score,
              pl2_score, flag_point, end_game, frame_valid, link_up, err_cnt}, '0);
        fv_seen = 0;
        word(16'h0017, 0); word(16'h0018, 0); word(16'h3300, 0);
        word(16'h0015 ^ 16'h0016 ^ 16'h0017 ^ 16'h0018 ^ 16'h3300, 0);
        idle(2);
        check("t6_no_commit", {fv_seen, pl2_posx, err_cnt}, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
